// File: rtl/apb_requester_arbiter.sv
// rtl/apb_requester_arbiter.sv - two-requester round-robin APB arbiter; optional counters under APB_ARB_STATS_EN
module apb_requester_arbiter #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    pclk,
   input  logic                    preset_n,
   input  logic                    req0_psel,
   input  logic                    req0_penable,
   input  logic                    req0_pwrite,
   input  logic [ADDR_WIDTH-1:0]   req0_paddr,
   input  logic [DATA_WIDTH-1:0]   req0_pwdata,
   input  logic [DATA_WIDTH/8-1:0] req0_pstrb,
   input  logic [2:0]              req0_pprot,
   output logic                    req0_pready,
   output logic                    req0_pslverr,
   output logic [DATA_WIDTH-1:0]   req0_prdata,
   input  logic                    req1_psel,
   input  logic                    req1_penable,
   input  logic                    req1_pwrite,
   input  logic [ADDR_WIDTH-1:0]   req1_paddr,
   input  logic [DATA_WIDTH-1:0]   req1_pwdata,
   input  logic [DATA_WIDTH/8-1:0] req1_pstrb,
   input  logic [2:0]              req1_pprot,
   output logic                    req1_pready,
   output logic                    req1_pslverr,
   output logic [DATA_WIDTH-1:0]   req1_prdata,
   output logic                    down_psel,
   output logic                    down_penable,
   output logic                    down_pwrite,
   output logic [ADDR_WIDTH-1:0]   down_paddr,
   output logic [DATA_WIDTH-1:0]   down_pwdata,
   output logic [DATA_WIDTH/8-1:0] down_pstrb,
   output logic [2:0]              down_pprot,
   input  logic                    down_pready,
   input  logic                    down_pslverr,
   input  logic [DATA_WIDTH-1:0]   down_prdata
`ifdef APB_ARB_STATS_EN
   ,
   input  logic                    stats_clear,
   output logic [15:0]             xfer_count0,
   output logic [15:0]             xfer_count1,
   output logic [15:0]             contention_count
`endif
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   state_t                  state_q, state_d;
   logic                    last_grant_q, last_grant_d;
   logic                    grant_q, grant_d;
   logic                    down_psel_q, down_psel_d;
   logic                    down_penable_q, down_penable_d;
   logic                    pwrite_q, pwrite_d;
   logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
   logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
   logic [STRB_WIDTH-1:0]   pstrb_q, pstrb_d;
   logic [2:0]              pprot_q, pprot_d;
   logic                    req0_pready_q, req0_pready_d;
   logic                    req0_pslverr_q, req0_pslverr_d;
   logic [DATA_WIDTH-1:0]   req0_prdata_q, req0_prdata_d;
   logic                    req1_pready_q, req1_pready_d;
   logic                    req1_pslverr_q, req1_pslverr_d;
   logic [DATA_WIDTH-1:0]   req1_prdata_q, req1_prdata_d;

   logic both_pending;
   logic pick;
   logic unused_penable;

   // penable from the requesters carries no information here: psel alone marks a pending request
   assign unused_penable = req0_penable ^ req1_penable;

   assign both_pending = req0_psel & req1_psel;
   // On a tie the requester that did not win last time goes; otherwise whoever is asking
   assign pick = both_pending ? ~last_grant_q : req1_psel;

   // Next-state and next-output computation for the arbitration FSM
   always_comb begin
      state_d        = state_q;
      last_grant_d   = last_grant_q;
      grant_d        = grant_q;
      down_psel_d    = down_psel_q;
      down_penable_d = down_penable_q;
      pwrite_d       = pwrite_q;
      paddr_d        = paddr_q;
      pwdata_d       = pwdata_q;
      pstrb_d        = pstrb_q;
      pprot_d        = pprot_q;
      req0_pready_d  = req0_pready_q;
      req0_pslverr_d = req0_pslverr_q;
      req0_prdata_d  = req0_prdata_q;
      req1_pready_d  = req1_pready_q;
      req1_pslverr_d = req1_pslverr_q;
      req1_prdata_d  = req1_prdata_q;
      case (state_q)
         IDLE: begin
            if (req0_psel | req1_psel) begin
               grant_d        = pick;
               last_grant_d   = pick;
               down_psel_d    = 1'b1;
               down_penable_d = 1'b0;
               state_d        = SETUP;
               if (pick) begin
                  pwrite_d = req1_pwrite;
                  paddr_d  = req1_paddr;
                  pwdata_d = req1_pwdata;
                  pstrb_d  = req1_pstrb;
                  pprot_d  = req1_pprot;
               end else begin
                  pwrite_d = req0_pwrite;
                  paddr_d  = req0_paddr;
                  pwdata_d = req0_pwdata;
                  pstrb_d  = req0_pstrb;
                  pprot_d  = req0_pprot;
               end
            end
         end
         SETUP: begin
            down_penable_d = 1'b1;
            state_d        = ACCESS;
         end
         ACCESS: begin
            if (down_pready) begin
               down_psel_d    = 1'b0;
               down_penable_d = 1'b0;
               state_d        = RESP;
               if (grant_q) begin
                  req1_pready_d  = 1'b1;
                  req1_prdata_d  = down_prdata;
                  req1_pslverr_d = down_pslverr;
               end else begin
                  req0_pready_d  = 1'b1;
                  req0_prdata_d  = down_prdata;
                  req0_pslverr_d = down_pslverr;
               end
            end
         end
         RESP: begin
            req0_pready_d  = 1'b0;
            req0_pslverr_d = 1'b0;
            req0_prdata_d  = '0;
            req1_pready_d  = 1'b0;
            req1_pslverr_d = 1'b0;
            req1_prdata_d  = '0;
            state_d        = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM state, latched transfer fields and all registered outputs
   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         state_q        <= IDLE;
         last_grant_q   <= 1'b1;
         grant_q        <= 1'b0;
         down_psel_q    <= 1'b0;
         down_penable_q <= 1'b0;
         pwrite_q       <= 1'b0;
         paddr_q        <= '0;
         pwdata_q       <= '0;
         pstrb_q        <= '0;
         pprot_q        <= '0;
         req0_pready_q  <= 1'b0;
         req0_pslverr_q <= 1'b0;
         req0_prdata_q  <= '0;
         req1_pready_q  <= 1'b0;
         req1_pslverr_q <= 1'b0;
         req1_prdata_q  <= '0;
      end else begin
         state_q        <= state_d;
         last_grant_q   <= last_grant_d;
         grant_q        <= grant_d;
         down_psel_q    <= down_psel_d;
         down_penable_q <= down_penable_d;
         pwrite_q       <= pwrite_d;
         paddr_q        <= paddr_d;
         pwdata_q       <= pwdata_d;
         pstrb_q        <= pstrb_d;
         pprot_q        <= pprot_d;
         req0_pready_q  <= req0_pready_d;
         req0_pslverr_q <= req0_pslverr_d;
         req0_prdata_q  <= req0_prdata_d;
         req1_pready_q  <= req1_pready_d;
         req1_pslverr_q <= req1_pslverr_d;
         req1_prdata_q  <= req1_prdata_d;
      end
   end

   assign down_psel    = down_psel_q;
   assign down_penable = down_penable_q;
   assign down_pwrite  = pwrite_q;
   assign down_paddr   = paddr_q;
   assign down_pwdata  = pwdata_q;
   assign down_pstrb   = pstrb_q;
   assign down_pprot   = pprot_q;
   assign req0_pready  = req0_pready_q;
   assign req0_pslverr = req0_pslverr_q;
   assign req0_prdata  = req0_prdata_q;
   assign req1_pready  = req1_pready_q;
   assign req1_pslverr = req1_pslverr_q;
   assign req1_prdata  = req1_prdata_q;

`ifdef APB_ARB_STATS_EN
   logic [15:0] xfer_count0_q, xfer_count0_d;
   logic [15:0] xfer_count1_q, xfer_count1_d;
   logic [15:0] contention_count_q, contention_count_d;

   // Saturating counters: completed responses per requester and tie cycles in IDLE
   always_comb begin
      xfer_count0_d      = xfer_count0_q;
      xfer_count1_d      = xfer_count1_q;
      contention_count_d = contention_count_q;
      if (stats_clear) begin
         xfer_count0_d      = '0;
         xfer_count1_d      = '0;
         contention_count_d = '0;
      end else begin
         if (state_q == RESP && !grant_q && xfer_count0_q != 16'hFFFF)
            xfer_count0_d = xfer_count0_q + 16'd1;
         if (state_q == RESP && grant_q && xfer_count1_q != 16'hFFFF)
            xfer_count1_d = xfer_count1_q + 16'd1;
         if (state_q == IDLE && both_pending && contention_count_q != 16'hFFFF)
            contention_count_d = contention_count_q + 16'd1;
      end
   end

   // Counter registers
   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         xfer_count0_q      <= '0;
         xfer_count1_q      <= '0;
         contention_count_q <= '0;
      end else begin
         xfer_count0_q      <= xfer_count0_d;
         xfer_count1_q      <= xfer_count1_d;
         contention_count_q <= contention_count_d;
      end
   end

   assign xfer_count0      = xfer_count0_q;
   assign xfer_count1      = xfer_count1_q;
   assign contention_count = contention_count_q;
`endif

endmodule

// File: tb/tb_apb_requester_arbiter.sv
// tb/tb_apb_requester_arbiter.sv - self-checking bench for apb_requester_arbiter
module tb_apb_requester_arbiter;
   localparam int AW = 12;
   localparam int DW = 32;
   localparam int SW = DW / 8;

   typedef struct packed {
      logic          w;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [SW-1:0] s;
      logic [2:0]    p;
   } xfer_t;

   typedef struct packed {
      logic [DW-1:0] d;
      logic          e;
   } rsp_t;

   logic pclk = 1'b0;
   logic preset_n;
   logic req0_psel, req0_penable, req0_pwrite;
   logic [AW-1:0] req0_paddr;
   logic [DW-1:0] req0_pwdata;
   logic [SW-1:0] req0_pstrb;
   logic [2:0] req0_pprot;
   logic req0_pready, req0_pslverr;
   logic [DW-1:0] req0_prdata;
   logic req1_psel, req1_penable, req1_pwrite;
   logic [AW-1:0] req1_paddr;
   logic [DW-1:0] req1_pwdata;
   logic [SW-1:0] req1_pstrb;
   logic [2:0] req1_pprot;
   logic req1_pready, req1_pslverr;
   logic [DW-1:0] req1_prdata;
   logic down_psel, down_penable, down_pwrite;
   logic [AW-1:0] down_paddr;
   logic [DW-1:0] down_pwdata;
   logic [SW-1:0] down_pstrb;
   logic [2:0] down_pprot;
   logic down_pready, down_pslverr;
   logic [DW-1:0] down_prdata;
`ifdef APB_ARB_STATS_EN
   logic stats_clear;
   logic [15:0] xfer_count0, xfer_count1, contention_count;
`endif

   apb_requester_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .pclk(pclk), .preset_n(preset_n),
      .req0_psel(req0_psel), .req0_penable(req0_penable), .req0_pwrite(req0_pwrite),
      .req0_paddr(req0_paddr), .req0_pwdata(req0_pwdata), .req0_pstrb(req0_pstrb),
      .req0_pprot(req0_pprot), .req0_pready(req0_pready), .req0_pslverr(req0_pslverr),
      .req0_prdata(req0_prdata),
      .req1_psel(req1_psel), .req1_penable(req1_penable), .req1_pwrite(req1_pwrite),
      .req1_paddr(req1_paddr), .req1_pwdata(req1_pwdata), .req1_pstrb(req1_pstrb),
      .req1_pprot(req1_pprot), .req1_pready(req1_pready), .req1_pslverr(req1_pslverr),
      .req1_prdata(req1_prdata),
      .down_psel(down_psel), .down_penable(down_penable), .down_pwrite(down_pwrite),
      .down_paddr(down_paddr), .down_pwdata(down_pwdata), .down_pstrb(down_pstrb),
      .down_pprot(down_pprot), .down_pready(down_pready), .down_pslverr(down_pslverr),
      .down_prdata(down_prdata)
`ifdef APB_ARB_STATS_EN
      ,
      .stats_clear(stats_clear), .xfer_count0(xfer_count0), .xfer_count1(xfer_count1),
      .contention_count(contention_count)
`endif
   );

   always #5 pclk = ~pclk;

   int cyc = 0;
   always @(posedge pclk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   xfer_t iss0[$], iss1[$], dn0[$], dn1[$];
   rsp_t  rq0[$], rq1[$];
   int    ord_q[$];
   logic  act0, act1, acc_first;
   xfer_t cur;
   int    cur_g;
   int    wait_cfg, acc_wait;
   logic [DW-1:0] rdata_cfg;
   logic  err_en;
   logic [AW-1:0] err_addr;
   int    setup_cyc[2], acc_cyc[2], rsp_cyc[2], issue_cyc[2], prdy_cnt[2];
   int    pen_cnt, psel_cnt, slv_cnt0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic xfer_t mk(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                input logic [SW-1:0] s, input logic [2:0] p);
      xfer_t t;
      t.w = w; t.a = a; t.d = d; t.s = s; t.p = p;
      return t;
   endfunction

   task automatic load(input int n);
      xfer_t t;
      rsp_t  r;
      if (n == 0) t = iss0.pop_front();
      else        t = iss1.pop_front();
      r.d = rdata_cfg;
      r.e = err_en && (t.a == err_addr);
      if (n == 0) begin
         dn0.push_back(t); rq0.push_back(r);
         req0_psel = 1'b1; req0_penable = 1'b0; req0_pwrite = t.w; req0_paddr = t.a;
         req0_pwdata = t.d; req0_pstrb = t.s; req0_pprot = t.p; act0 = 1'b1;
      end else begin
         dn1.push_back(t); rq1.push_back(r);
         req1_psel = 1'b1; req1_penable = 1'b0; req1_pwrite = t.w; req1_paddr = t.a;
         req1_pwdata = t.d; req1_pstrb = t.s; req1_pprot = t.p; act1 = 1'b1;
      end
      issue_cyc[n] = cyc;
   endtask

   task automatic tick();
      rsp_t r;
      @(negedge pclk);
      if (!req0_pready) begin
         chk("req0_prdata_idle", req0_prdata, 0);
         chk("req0_pslverr_idle", req0_pslverr, 0);
      end
      if (!req1_pready) begin
         chk("req1_prdata_idle", req1_prdata, 0);
         chk("req1_pslverr_idle", req1_pslverr, 0);
      end
      chk("pready_both", req0_pready & req1_pready, 0);
      if (down_penable) chk("penable_without_psel", down_psel, 1);
      if (down_psel) psel_cnt++;
      if (req0_pslverr) slv_cnt0++;
      if (down_psel && !down_penable) begin
         chk("setup_expected", ord_q.size() > 0, 1);
         if (ord_q.size() > 0) begin
            cur_g = ord_q.pop_front();
            chk("setup_req_queue", (cur_g == 0) ? dn0.size() > 0 : dn1.size() > 0, 1);
            if (cur_g == 0 && dn0.size() > 0) cur = dn0.pop_front();
            if (cur_g == 1 && dn1.size() > 0) cur = dn1.pop_front();
            setup_cyc[cur_g] = cyc;
            acc_first = 1'b1;
            chk("setup_paddr", down_paddr, cur.a);
            chk("setup_pwrite", down_pwrite, cur.w);
            chk("setup_pwdata", down_pwdata, cur.d);
            chk("setup_pstrb", down_pstrb, cur.s);
            chk("setup_pprot", down_pprot, cur.p);
         end
      end
      if (down_psel && down_penable) begin
         pen_cnt++;
         if (acc_first) begin
            acc_cyc[cur_g] = cyc;
            acc_first = 1'b0;
         end
         chk("access_paddr", down_paddr, cur.a);
         chk("access_pwdata", down_pwdata, cur.d);
         chk("access_pwrite", down_pwrite, cur.w);
      end
      if (req0_pready) begin
         prdy_cnt[0]++; rsp_cyc[0] = cyc;
         chk("req0_rsp_expected", rq0.size() > 0, 1);
         if (rq0.size() > 0) begin
            r = rq0.pop_front();
            chk("req0_prdata", req0_prdata, r.d);
            chk("req0_pslverr", req0_pslverr, r.e);
         end
      end
      if (req1_pready) begin
         prdy_cnt[1]++; rsp_cyc[1] = cyc;
         chk("req1_rsp_expected", rq1.size() > 0, 1);
         if (rq1.size() > 0) begin
            r = rq1.pop_front();
            chk("req1_prdata", req1_prdata, r.d);
            chk("req1_pslverr", req1_pslverr, r.e);
         end
      end
      // downstream completer model
      if (down_psel && down_penable) begin
         down_pready = (acc_wait >= wait_cfg);
         acc_wait++;
      end else begin
         down_pready = 1'b0;
         acc_wait = 0;
      end
      down_prdata  = rdata_cfg;
      down_pslverr = err_en && (down_paddr == err_addr);
      // requester drivers
      if (act0) req0_penable = 1'b1;
      if (act1) req1_penable = 1'b1;
      if (act0 && req0_pready) begin act0 = 1'b0; req0_psel = 1'b0; req0_penable = 1'b0; end
      if (act1 && req1_pready) begin act1 = 1'b0; req1_psel = 1'b0; req1_penable = 1'b0; end
      if (!act0 && iss0.size() > 0) load(0);
      if (!act1 && iss1.size() > 0) load(1);
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while ((act0 || act1 || iss0.size() > 0 || iss1.size() > 0) && n < 300) begin
         tick();
         n++;
      end
      chk({tag, "_done"}, act0 || act1 || iss0.size() > 0 || iss1.size() > 0, 0);
      tick();
   endtask

   task automatic clear_counts();
      for (int i = 0; i < 2; i++) prdy_cnt[i] = 0;
      pen_cnt = 0; psel_cnt = 0; slv_cnt0 = 0;
   endtask

   initial begin
      preset_n = 1'b0;
      req0_psel = 0; req0_penable = 0; req0_pwrite = 0; req0_paddr = '0; req0_pwdata = '0;
      req0_pstrb = '0; req0_pprot = '0;
      req1_psel = 0; req1_penable = 0; req1_pwrite = 0; req1_paddr = '0; req1_pwdata = '0;
      req1_pstrb = '0; req1_pprot = '0;
      down_pready = 0; down_pslverr = 0; down_prdata = '0;
`ifdef APB_ARB_STATS_EN
      stats_clear = 1'b0;
`endif
      act0 = 0; act1 = 0; acc_first = 0; cur = '0; cur_g = 0;
      wait_cfg = 0; acc_wait = 0; rdata_cfg = '0; err_en = 0; err_addr = '0;
      clear_counts();

      // reset state
      tick(); tick();
      chk("rst_down_ctrl", {down_psel, down_penable, down_pwrite}, 0);
      chk("rst_down_paddr", down_paddr, 0);
      chk("rst_down_pwdata", down_pwdata, 0);
      chk("rst_down_pstrb_pprot", {down_pstrb, down_pprot}, 0);
      chk("rst_req_pready", {req0_pready, req1_pready}, 0);
`ifdef APB_ARB_STATS_EN
      chk("rst_stats", {xfer_count0, xfer_count1}, 0);
      chk("rst_contention", contention_count, 0);
`endif
      preset_n = 1'b1;
      tick();

      // single req0 write, completer ready at once
      clear_counts();
      rdata_cfg = 32'h0;
      iss0.push_back(mk(1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 3'b000));
      ord_q.push_back(0);
      wait_done("t1");
      chk("t1_setup_lat", setup_cyc[0] - issue_cyc[0], 1);
      chk("t1_access_lat", acc_cyc[0] - issue_cyc[0], 2);
      chk("t1_pready_lat", rsp_cyc[0] - issue_cyc[0], 3);
      chk("t1_req0_pready_cycles", prdy_cnt[0], 1);
      chk("t1_req1_pready_cycles", prdy_cnt[1], 0);

      // req1 read with five wait states
      clear_counts();
      wait_cfg = 5; rdata_cfg = 32'h12345678;
      iss1.push_back(mk(1'b0, 12'h804, 32'h0, 4'h0, 3'b001));
      ord_q.push_back(1);
      wait_done("t2");
      chk("t2_penable_cycles", pen_cnt, 6);
      chk("t2_psel_cycles", psel_cnt, 7);
      chk("t2_req1_pready_cycles", prdy_cnt[1], 1);
      chk("t2_req0_pready_cycles", prdy_cnt[0], 0);

      // simultaneous requests straight after reset: req0 first
      preset_n = 1'b0;
      tick();
      preset_n = 1'b1;
      clear_counts();
      wait_cfg = 0; rdata_cfg = 32'hA5A50001;
      iss0.push_back(mk(1'b0, 12'h100, 32'h0, 4'h0, 3'b000));
      iss1.push_back(mk(1'b1, 12'h200, 32'hCAFEF00D, 4'h3, 3'b010));
      ord_q.push_back(0); ord_q.push_back(1);
      wait_done("t3");
      chk("t3_req0_setup_lat", setup_cyc[0] - issue_cyc[0], 1);
      chk("t3_req1_setup_after_req0_rsp", setup_cyc[1] - rsp_cyc[0], 2);
      chk("t3_pready_counts", {prdy_cnt[0][7:0], prdy_cnt[1][7:0]}, 16'h0101);

      // ten streamed transfers, five from each side
`ifdef APB_ARB_STATS_EN
      stats_clear = 1'b1;
      tick();
      stats_clear = 1'b0;
      tick();
      chk("stats_cleared", {xfer_count0, xfer_count1}, 0);
      chk("contention_cleared", contention_count, 0);
`endif
      clear_counts();
      rdata_cfg = 32'h5A5A0000;
      for (int i = 0; i < 5; i++) begin
         iss0.push_back(mk(1'b1, 12'h300 + 12'(i * 4), 32'h1000 + i, 4'hF, 3'b000));
         iss1.push_back(mk(1'b0, 12'h400 + 12'(i * 4), 32'h0, 4'h0, 3'b100));
         ord_q.push_back(0); ord_q.push_back(1);
      end
      wait_done("t4");
      chk("t4_req0_done", prdy_cnt[0], 5);
      chk("t4_req1_done", prdy_cnt[1], 5);
      chk("t4_order_consumed", ord_q.size(), 0);
`ifdef APB_ARB_STATS_EN
      chk("t4_xfer_count0", xfer_count0, 5);
      chk("t4_xfer_count1", xfer_count1, 5);
      chk("t4_contention_ge9", contention_count >= 16'd9, 1);
`endif

      // slave error on one write, clean follow-up
      clear_counts();
      err_en = 1'b1; err_addr = 12'h020; rdata_cfg = 32'h0;
      iss0.push_back(mk(1'b1, 12'h020, 32'h00000001, 4'hF, 3'b000));
      iss0.push_back(mk(1'b1, 12'h024, 32'h00000002, 4'hF, 3'b000));
      ord_q.push_back(0); ord_q.push_back(0);
      wait_done("t5");
      chk("t5_pslverr_cycles", slv_cnt0, 1);
      chk("t5_req0_done", prdy_cnt[0], 2);
      err_en = 1'b0;

      // reset while stalled in ACCESS
      clear_counts();
      wait_cfg = 1000;
      iss0.push_back(mk(1'b0, 12'h030, 32'h0, 4'h0, 3'b000));
      ord_q.push_back(0);
      begin
         int n = 0;
         while (!(down_psel && down_penable) && n < 20) begin
            tick();
            n++;
         end
      end
      chk("t6_reached_access", down_penable, 1);
      #2 preset_n = 1'b0;
      #1;
      chk("t6_async_down_ctrl", {down_psel, down_penable}, 0);
      chk("t6_async_pready", {req0_pready, req1_pready}, 0);
      chk("t6_async_paddr", down_paddr, 0);
      iss0.delete(); iss1.delete(); dn0.delete(); dn1.delete();
      rq0.delete(); rq1.delete(); ord_q.delete();
      act0 = 0; act1 = 0; acc_first = 0;
      req0_psel = 0; req0_penable = 0; req1_psel = 0; req1_penable = 0;
      down_pready = 0; acc_wait = 0;
      tick();
      preset_n = 1'b1;
      tick();
      clear_counts();
      wait_cfg = 0; rdata_cfg = 32'h0BADF00D;
      iss1.push_back(mk(1'b0, 12'h044, 32'h0, 4'h0, 3'b000));
      ord_q.push_back(1);
      wait_done("t6");
      chk("t6_req1_pready_cycles", prdy_cnt[1], 1);
      chk("t6_req1_setup_lat", setup_cyc[1] - issue_cyc[1], 1);

      chk("end_order_empty", ord_q.size(), 0);
      chk("end_rsp_empty", rq0.size() + rq1.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
